// File: rtl/alu_op_driver_if.sv
// Request, ALU-drive and response signals of the ALU requester.
// slave = the driver itself; master = control logic plus the ALU datapath.
interface alu_op_driver_if #(
  parameter int WIDTH = 6,
  parameter int OPW   = 3
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [OPW-1:0]   req_op;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_z;
  logic             alu_overflow;
  logic             alu_c_out;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_z;
  logic             rsp_overflow;
  logic             rsp_c_out;
  logic             rsp_zero;

  logic             busy;
  logic [7:0]       op_count;

  modport slave (
    input  req_valid, req_a, req_b, req_op,
    output req_ready,
    output alu_a, alu_b, alu_op,
    input  alu_z, alu_overflow, alu_c_out,
    output rsp_valid, rsp_z, rsp_overflow, rsp_c_out, rsp_zero,
    input  rsp_ready,
    output busy, op_count
  );

  modport master (
    output req_valid, req_a, req_b, req_op,
    input  req_ready,
    input  alu_a, alu_b, alu_op,
    output alu_z, alu_overflow, alu_c_out,
    input  rsp_valid, rsp_z, rsp_overflow, rsp_c_out, rsp_zero,
    output rsp_ready,
    input  busy, op_count
  );
endinterface

// File: rtl/alu_op_driver.sv
// Drives registered operands into a combinational ALU, samples the result SETTLE
// edges after accept and holds it on rsp_* until rsp_ready; one request in flight.
module alu_op_driver #(
  parameter int WIDTH  = 6,
  parameter int OPW    = 3,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  alu_op_driver_if.slave   bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]       state;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [OPW-1:0]   alu_op_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_z_q;
  logic             rsp_overflow_q;
  logic             rsp_c_out_q;
  logic             rsp_zero_q;
  logic [7:0]       op_count_q;

  assign bus.req_ready    = (state == IDLE);
  assign bus.busy         = (state != IDLE);
  assign bus.alu_a        = alu_a_q;
  assign bus.alu_b        = alu_b_q;
  assign bus.alu_op       = alu_op_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_z        = rsp_z_q;
  assign bus.rsp_overflow = rsp_overflow_q;
  assign bus.rsp_c_out    = rsp_c_out_q;
  assign bus.rsp_zero     = rsp_zero_q;
  assign bus.op_count     = op_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_op_q       <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_z_q        <= '0;
      rsp_overflow_q <= 1'b0;
      rsp_c_out_q    <= 1'b0;
      rsp_zero_q     <= 1'b0;
      op_count_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            alu_a_q  <= bus.req_a;
            alu_b_q  <= bus.req_b;
            alu_op_q <= bus.req_op;
            cnt      <= 4'(SETTLE - 1);
            state    <= DRIVE;
          end
        end
        DRIVE: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            // Flags are forwarded untouched, whatever unit produced them.
            rsp_z_q        <= bus.alu_z;
            rsp_overflow_q <= bus.alu_overflow;
            rsp_c_out_q    <= bus.alu_c_out;
            rsp_zero_q     <= (bus.alu_z == '0);
            rsp_valid_q    <= 1'b1;
            state          <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            op_count_q  <= op_count_q + 8'd1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_op_driver.sv
// Two drivers (SETTLE=1 and SETTLE=4) share one stimulus stream and are compared
// every cycle against a transaction-level model; a few literal checks pin the model.
module tb_alu_op_driver;
  localparam int W = 6;
  localparam int O = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req_valid = 1'b0;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic [O-1:0] req_op = '0;
  int           flag_mode = 0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_op_driver_if #(.WIDTH(W), .OPW(O)) bus1 ();
  alu_op_driver_if #(.WIDTH(W), .OPW(O)) bus2 ();

  // Stub ALU: bitwise XNOR; flags tied 0, tied 1, or an operand-dependent pattern.
  function automatic logic [1:0] stub_flags(int mode, logic [W-1:0] a, logic [W-1:0] b,
                                            logic [O-1:0] op);
    if (mode == 0) return 2'b00;
    if (mode == 1) return 2'b11;
    return {a[W-1] ^ b[0], op[0]};
  endfunction

  assign bus1.req_valid = req_valid;
  assign bus1.req_a     = req_a;
  assign bus1.req_b     = req_b;
  assign bus1.req_op    = req_op;
  assign bus1.rsp_ready = rsp_ready;
  assign bus1.alu_z     = ~(bus1.alu_a ^ bus1.alu_b);
  assign {bus1.alu_overflow, bus1.alu_c_out} = stub_flags(flag_mode, bus1.alu_a, bus1.alu_b, bus1.alu_op);

  assign bus2.req_valid = req_valid;
  assign bus2.req_a     = req_a;
  assign bus2.req_b     = req_b;
  assign bus2.req_op    = req_op;
  assign bus2.rsp_ready = rsp_ready;
  assign bus2.alu_z     = ~(bus2.alu_a ^ bus2.alu_b);
  assign {bus2.alu_overflow, bus2.alu_c_out} = stub_flags(flag_mode, bus2.alu_a, bus2.alu_b, bus2.alu_op);

  alu_op_driver #(.WIDTH(W), .OPW(O), .SETTLE(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  alu_op_driver #(.WIDTH(W), .OPW(O), .SETTLE(4)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  // Model: one transaction in flight per driver; the result appears S edges after accept.
  int           S [2] = '{1, 4};
  bit           m_busy [2];
  bit           m_rspv [2];
  int           m_age [2];
  logic [W-1:0] m_a [2];
  logic [W-1:0] m_b [2];
  logic [O-1:0] m_op [2];
  logic [W-1:0] m_z [2];
  bit           m_ovf [2];
  bit           m_cout [2];
  bit           m_zero [2];
  int           m_cnt [2];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        m_busy[k] = 0; m_rspv[k] = 0; m_age[k] = 0;
        m_a[k] = '0; m_b[k] = '0; m_op[k] = '0; m_z[k] = '0;
        m_ovf[k] = 0; m_cout[k] = 0; m_zero[k] = 0; m_cnt[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (!m_busy[k]) begin
          if (req_valid) begin
            m_a[k] = req_a; m_b[k] = req_b; m_op[k] = req_op;
            m_busy[k] = 1; m_age[k] = 0;
          end
        end else if (!m_rspv[k]) begin
          m_age[k] = m_age[k] + 1;
          if (m_age[k] == S[k]) begin
            m_z[k] = ~(m_a[k] ^ m_b[k]);
            {m_ovf[k], m_cout[k]} = stub_flags(flag_mode, m_a[k], m_b[k], m_op[k]);
            m_zero[k] = (m_z[k] == 0);
            m_rspv[k] = 1;
          end
        end else if (rsp_ready) begin
          m_rspv[k] = 0; m_busy[k] = 0;
          m_cnt[k] = (m_cnt[k] + 1) % 256;
        end
      end
    end
  end

  task automatic check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic cmp(string t, int k, logic rdy, logic bsy, logic [W-1:0] a, logic [W-1:0] b,
                     logic [O-1:0] op, logic rv, logic [W-1:0] z, logic ov, logic co,
                     logic ze, logic [7:0] cnt);
    check({t, ".req_ready"}, int'(rdy), int'(!m_busy[k]));
    check({t, ".busy"}, int'(bsy), int'(m_busy[k]));
    check({t, ".alu_a"}, int'(a), int'(m_a[k]));
    check({t, ".alu_b"}, int'(b), int'(m_b[k]));
    check({t, ".alu_op"}, int'(op), int'(m_op[k]));
    check({t, ".rsp_valid"}, int'(rv), int'(m_rspv[k]));
    check({t, ".rsp_z"}, int'(z), int'(m_z[k]));
    check({t, ".rsp_overflow"}, int'(ov), int'(m_ovf[k]));
    check({t, ".rsp_c_out"}, int'(co), int'(m_cout[k]));
    check({t, ".rsp_zero"}, int'(ze), int'(m_zero[k]));
    check({t, ".op_count"}, int'(cnt), m_cnt[k]);
  endtask

  always @(negedge clk) begin
    cmp("s1", 0, bus1.req_ready, bus1.busy, bus1.alu_a, bus1.alu_b, bus1.alu_op, bus1.rsp_valid,
        bus1.rsp_z, bus1.rsp_overflow, bus1.rsp_c_out, bus1.rsp_zero, bus1.op_count);
    cmp("s4", 1, bus2.req_ready, bus2.busy, bus2.alu_a, bus2.alu_b, bus2.alu_op, bus2.rsp_valid,
        bus2.rsp_z, bus2.rsp_overflow, bus2.rsp_c_out, bus2.rsp_zero, bus2.op_count);
  end

  // Issue one request to both idle drivers and wait until both hold a response.
  task automatic start_txn(logic [W-1:0] a, logic [W-1:0] b, logic [O-1:0] op,
                           output int lat1, output int lat2);
    check("idle_before_req.s1", int'(bus1.req_ready), 1);
    check("idle_before_req.s4", int'(bus2.req_ready), 1);
    rsp_ready = 1'b0;
    req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat1 = 99; lat2 = 99;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (bus1.rsp_valid && lat1 == 99) lat1 = n;
      if (bus2.rsp_valid && lat2 == 99) lat2 = n;
      if (lat1 != 99 && lat2 != 99) break;
    end
    check("rsp_timeout", int'(lat1 != 99 && lat2 != 99), 1);
  endtask

  task automatic finish_txn();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  int l1, l2;

  initial begin
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset asserted mid-clock with transactions in flight.
    req_a = 6'd7; req_b = 6'd9; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("rst.rsp_valid", int'(bus1.rsp_valid), 0);
    check("rst.req_ready", int'(bus1.req_ready), 1);
    check("rst.busy", int'(bus2.busy), 0);
    check("rst.alu_a", int'(bus1.alu_a), 0);
    check("rst.rsp_z", int'(bus1.rsp_z), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // XNOR of 101010 and 100110.
    start_txn(6'b101010, 6'b100110, 3'd5, l1, l2);
    check("lat.s1", l1, 1);
    check("lat.s4", l2, 4);
    finish_txn();
    check("t2.alu_op", int'(bus1.alu_op), 5);
    check("t2.rsp_z", int'(bus1.rsp_z), 6'b110011);
    check("t2.rsp_zero", int'(bus1.rsp_zero), 0);
    check("t2.flags", int'({bus1.rsp_overflow, bus1.rsp_c_out}), 0);
    check("t2.op_count", int'(bus1.op_count), 1);

    // Zero result held under backpressure; requests in RESP ignored.
    start_txn(6'b000000, 6'b111111, 3'd2, l1, l2);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_a = W'($urandom); req_b = W'($urandom);
      @(posedge clk); #1;
      check("hold.rsp_z", int'(bus1.rsp_z), 0);
      check("hold.rsp_zero", int'(bus1.rsp_zero), 1);
      check("hold.alu_b", int'(bus1.alu_b), 6'b111111);
      check("hold.req_ready", int'(bus1.req_ready), 0);
    end
    req_valid = 1'b0;
    finish_txn();
    check("t3.busy", int'(bus1.busy), 0);
    check("t3.op_count", int'(bus1.op_count), 2);

    // Forced flags with SETTLE=4.
    flag_mode = 1;
    start_txn(W'($urandom), W'($urandom), O'($urandom), l1, l2);
    check("t4.lat", l2, 4);
    check("t4.ovf", int'(bus2.rsp_overflow), 1);
    check("t4.cout", int'(bus2.rsp_c_out), 1);
    finish_txn();
    flag_mode = 0;

    // Reset while holding a response.
    start_txn(6'd3, 6'd12, 3'd1, l1, l2);
    #2 reset = 1'b1;
    #1;
    check("rst_resp.rsp_valid", int'(bus1.rsp_valid), 0);
    check("rst_resp.rsp_valid4", int'(bus2.rsp_valid), 0);
    check("rst_resp.op_count", int'(bus1.op_count), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    start_txn(6'd33, 6'd17, 3'd6, l1, l2);
    check("after_rst.lat", l1, 1);
    finish_txn();
    check("after_rst.op_count", int'(bus1.op_count), 1);

    // 256 back-to-back transactions on the SETTLE=1 driver, 3 cycles each.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    req_valid = 1'b1; rsp_ready = 1'b1;
    repeat (384) begin
      req_a = W'($urandom); req_b = W'($urandom);
      @(posedge clk); #1;
    end
    check("wrap.half", int'(bus1.op_count), 128);
    repeat (383) @(posedge clk);
    #1;
    check("wrap.255", int'(bus1.op_count), 255);
    @(posedge clk); #1;
    check("wrap.0", int'(bus1.op_count), 0);
    check("wrap.idle", int'(bus1.req_ready), 1);
    req_valid = 1'b0; rsp_ready = 1'b0;

    // Random traffic with occasional resets.
    flag_mode = 2;
    for (int i = 0; i < 800; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      rsp_ready = ($urandom_range(0, 3) != 0);
      req_a = W'($urandom); req_b = W'($urandom); req_op = O'($urandom);
      reset = ($urandom_range(0, 99) == 0);
      @(posedge clk); #1;
    end
    reset = 1'b0; req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
